// File: rtl/uart_pkg.sv
// Shared constants for the UART timing engine: counter mode and direction encodings.
package uart_pkg;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  localparam logic DIR_DOWN     = 1'b0;
  localparam logic DIR_UP       = 1'b1;

endpackage

// File: rtl/tick_counter_prescaler.sv
// Programmable prescaler: pre_cnt runs 0..div_val while enabled and raises a
// combinational tick on the terminal cycle. clr restarts the period at 0.
module tick_prescaler
  import uart_pkg::*;
#(
  parameter int PRE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 hard_rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [PRE_WIDTH-1:0] div_val,
  output logic                 tick
);

  localparam logic [PRE_WIDTH-1:0] PRE_ONE = PRE_WIDTH'(1);

  logic [PRE_WIDTH-1:0] pre_cnt;
  logic                 pre_hit;

  // Equality compare only: if div_val is lowered below pre_cnt the count
  // rolls through all-ones before it can match again.
  always_comb begin
    pre_hit = (pre_cnt == div_val);
    tick    = en && pre_hit;
  end

  // Period counter; holds while disabled so the tick phase survives en gaps.
  always_ff @(posedge clk or posedge hard_rst) begin
    if (hard_rst) begin
      pre_cnt <= '0;
    end else if (clr) begin
      pre_cnt <= '0;
    end else if (en) begin
      if (pre_hit) pre_cnt <= '0;
      else         pre_cnt <= pre_cnt + PRE_ONE;
    end
  end

endmodule

// File: rtl/tick_counter.sv
// Timing engine for the UART FSMDs: prescaled tick drives an up/down main
// counter with parallel load, wrap or one-shot mode, a one-cycle terminal-count
// pulse and a sticky done flag.
module tick_counter
  import uart_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PRE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 hard_rst,
  input  logic                 soft_rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  input  logic                 up_dn,
  input  logic                 mode,
  input  logic [PRE_WIDTH-1:0] div_val,
  input  logic [WIDTH-1:0]     end_val,
  output logic [WIDTH-1:0]     cnt_out,
  output logic                 tick,
  output logic                 tc,
  output logic                 done
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic pre_en;
  logic pre_clr;
  logic at_term;

  // A finished one-shot freezes the prescaler as well, so tick stays low.
  assign pre_en  = en && !done;
  assign pre_clr = soft_rst || load;

  tick_prescaler #(
    .PRE_WIDTH (PRE_WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .hard_rst (hard_rst),
    .clr      (pre_clr),
    .en       (pre_en),
    .div_val  (div_val),
    .tick     (tick)
  );

  // Terminal position depends on direction: end_val going up, zero going down.
  always_comb begin
    if (up_dn == DIR_UP) at_term = (cnt_out == end_val);
    else                 at_term = (cnt_out == '0);
  end

  // Main counter, terminal pulse and sticky done; soft_rst beats load beats count.
  always_ff @(posedge clk or posedge hard_rst) begin
    if (hard_rst) begin
      cnt_out <= '0;
      tc      <= 1'b0;
      done    <= 1'b0;
    end else if (soft_rst) begin
      cnt_out <= '0;
      tc      <= 1'b0;
      done    <= 1'b0;
    end else if (load) begin
      cnt_out <= load_val;
      tc      <= 1'b0;
      done    <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (tick) begin
        if (at_term) begin
          tc <= 1'b1;
          if (mode == MODE_ONESHOT) begin
            done <= 1'b1;
          end else if (up_dn == DIR_UP) begin
            cnt_out <= '0;
          end else begin
            cnt_out <= end_val;
          end
        end else if (up_dn == DIR_UP) begin
          cnt_out <= cnt_out + CNT_ONE;
        end else begin
          cnt_out <= cnt_out - CNT_ONE;
        end
      end
    end
  end

endmodule
